answer_key_encoder: RTL and testbench

// - Producer side of the game core's answer interface: turns raw note push-buttons into

---
 rtl/answer_key_encoder_pkg.sv | 19 +
 rtl/answer_key_encoder_btn_sync.sv | 26 ++
 rtl/answer_key_encoder.sv | 137 +++++++++++++
 tb/tb_answer_key_encoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/answer_key_encoder_pkg.sv
// Shared game definitions: note codes, key-to-code mapping and the answer-key FSM states.
package answer_key_encoder_pkg;

  localparam int unsigned NOTE_W = 4;
  localparam logic [NOTE_W-1:0] NOTE_SILENT = 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } key_state_e;

  // Key i plays note code i+1; code 0 is reserved for silence.
  function automatic logic [NOTE_W-1:0] key_to_code(input logic [NOTE_W-1:0] idx);
    return idx + NOTE_W'(1);
  endfunction

endpackage

// File: rtl/answer_key_encoder_btn_sync.sv
// Two-flop synchronizer bank bringing asynchronous button levels into the clk domain.
module answer_key_encoder_btn_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/answer_key_encoder.sv
// Turns raw note push-buttons into debounced single-cycle answer strobes for the game core.
// One strobe per physical press; a full debounced release is needed before the next one.
module answer_key_encoder
  import answer_key_encoder_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] btn,
  input  logic                accept_en,
  output logic [NOTE_W-1:0]   answer,
  output logic                answer_enable,
  output logic                key_busy,
  output logic                multi_press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] s;

  key_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NOTE_W-1:0]   key_idx_q, key_idx_d;
  logic [NOTE_W-1:0]   answer_q, answer_d;
  logic                ans_en_q, ans_en_d;
  logic                busy_q, busy_d;
  logic                multi_q, multi_d;

  logic                s_onehot_c;
  logic [NOTE_W-1:0]   s_idx_c;
  logic [NUM_KEYS-1:0] held_mask_c;

  answer_key_encoder_btn_sync #(
    .WIDTH(NUM_KEYS)
  ) u_btn_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (btn),
    .q_o    (s)
  );

  // Decode the synchronized vector: one-hot test and index of the pressed key.
  always_comb begin
    s_onehot_c = (s != '0) && ((s & (s - NUM_KEYS'(1))) == '0);
    s_idx_c    = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (s[i]) s_idx_c = NOTE_W'(i);
    end
    held_mask_c = NUM_KEYS'(1) << key_idx_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_idx_q <= '0;
      answer_q  <= NOTE_SILENT;
      ans_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_idx_q <= key_idx_d;
      answer_q  <= answer_d;
      ans_en_q  <= ans_en_d;
      busy_q    <= busy_d;
      multi_q   <= multi_d;
    end
  end

  // Counter restarts on every state entry and stops at CNT_LAST via the exit transition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_idx_d = key_idx_q;
    answer_d  = answer_q;
    ans_en_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_onehot_c) begin
          key_idx_d = s_idx_c;
          state_d   = DEBOUNCE;
          cnt_d     = '0;
        end
      end
      DEBOUNCE: begin
        if (s != held_mask_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          if (accept_en) begin
            answer_d = key_to_code(key_idx_q);
            ans_en_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (s == '0) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d  = (state_d != IDLE);
    multi_d = ($countones(s) > 1);
  end

  assign answer        = answer_q;
  assign answer_enable = ans_en_q;
  assign key_busy      = busy_q;
  assign multi_press   = multi_q;

endmodule

// File: tb/tb_answer_key_encoder.sv
// Scoreboard bench for answer_key_encoder: expected strobes are queued with their due cycle.
module tb_answer_key_encoder;

  localparam int unsigned NUM_KEYS = 8;
  localparam int unsigned DEB      = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NUM_KEYS-1:0] btn = '0;
  logic                accept_en = 1'b0;
  logic [3:0]          answer;
  logic                answer_enable;
  logic                key_busy;
  logic                multi_press;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pulses = 0;

  answer_key_encoder #(
    .NUM_KEYS       (NUM_KEYS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn          (btn),
    .accept_en    (accept_en),
    .answer       (answer),
    .answer_enable(answer_enable),
    .key_busy     (key_busy),
    .multi_press  (multi_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance n rising edges, then settle just after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A clean rise driven now must strobe DEB+3 edges later.
  task automatic expect_press(input logic [3:0] code);
    exp_t e;
    e.code = code;
    e.cyc  = 32'(cyc + DEB + 3);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n && answer_enable === 1'b1) begin
      exp_t e;
      n_pulses++;
      check_eq("pulse_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("pulse_code", 32'(answer), 32'(e.code));
        check_eq("pulse_cycle", 32'(cyc), e.cyc);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    accept_en = 1'b1;
    tick(3);
    check_eq("rst_answer", 32'(answer), 32'd0);
    check_eq("rst_answer_enable", 32'(answer_enable), 32'd0);
    check_eq("rst_key_busy", 32'(key_busy), 32'd0);
    check_eq("rst_multi_press", 32'(multi_press), 32'd0);
    reset_n = 1'b1;
    tick(3);

    // Clean press of key 2
    btn = 8'h04;
    expect_press(4'd3);
    tick(4);
    check_eq("clean_busy_debounce", 32'(key_busy), 32'd1);
    tick(16);
    btn = 8'h00;
    tick(3);
    check_eq("clean_busy_release", 32'(key_busy), 32'd1);
    tick(17);
    check_eq("clean_busy_idle", 32'(key_busy), 32'd0);
    check_eq("clean_answer", 32'(answer), 32'd3);
    check_eq("clean_sb_drain", 32'(sb.size()), 32'd0);

    // Bouncing key 0, timed from the last rising edge
    for (int t = 0; t < 5; t++) begin
      btn = (t % 2 == 0) ? 8'h01 : 8'h00;
      if (t == 4) expect_press(4'd1);
      tick(2);
    end
    tick(10);
    btn = 8'h00;
    tick(20);
    check_eq("bounce_answer", 32'(answer), 32'd1);
    check_eq("bounce_sb_drain", 32'(sb.size()), 32'd0);

    // Chord: two keys at once never leave IDLE
    btn = 8'h06;
    tick(5);
    check_eq("chord_multi", 32'(multi_press), 32'd1);
    check_eq("chord_busy", 32'(key_busy), 32'd0);
    tick(15);
    check_eq("chord_multi_held", 32'(multi_press), 32'd1);
    check_eq("chord_busy_held", 32'(key_busy), 32'd0);
    btn = 8'h00;
    tick(5);
    check_eq("chord_multi_clear", 32'(multi_press), 32'd0);
    tick(5);
    btn = 8'h80;
    expect_press(4'd8);
    tick(20);
    btn = 8'h00;
    tick(20);
    check_eq("chord_key7_answer", 32'(answer), 32'd8);

    // Gated accept: press consumed silently, answer kept
    accept_en = 1'b0;
    btn = 8'h10;
    tick(10);
    check_eq("gated_busy", 32'(key_busy), 32'd1);
    check_eq("gated_answer_held", 32'(answer), 32'd8);
    tick(10);
    btn = 8'h00;
    tick(20);
    check_eq("gated_answer_after", 32'(answer), 32'd8);
    accept_en = 1'b1;
    btn = 8'h10;
    expect_press(4'd5);
    tick(20);
    btn = 8'h00;
    tick(20);
    check_eq("gated_second_answer", 32'(answer), 32'd5);

    // Hold and roll: only the first key strobes
    btn = 8'h02;
    expect_press(4'd2);
    tick(10);
    btn = 8'h22;
    tick(5);
    check_eq("roll_multi", 32'(multi_press), 32'd1);
    check_eq("roll_busy", 32'(key_busy), 32'd1);
    tick(5);
    btn = 8'h20;
    tick(10);
    check_eq("roll_busy_second", 32'(key_busy), 32'd1);
    check_eq("roll_answer", 32'(answer), 32'd2);
    btn = 8'h00;
    tick(3);
    check_eq("roll_busy_release", 32'(key_busy), 32'd1);
    tick(20);
    check_eq("roll_busy_idle", 32'(key_busy), 32'd0);
    check_eq("roll_sb_drain", 32'(sb.size()), 32'd0);

    // Reset two cycles into DEBOUNCE
    btn = 8'h08;
    tick(5);
    check_eq("rstmid_busy_before", 32'(key_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rstmid_answer", 32'(answer), 32'd0);
    check_eq("rstmid_answer_enable", 32'(answer_enable), 32'd0);
    check_eq("rstmid_key_busy", 32'(key_busy), 32'd0);
    check_eq("rstmid_multi_press", 32'(multi_press), 32'd0);
    btn = 8'h00;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    btn = 8'h40;
    expect_press(4'd7);
    tick(20);
    btn = 8'h00;
    tick(20);
    check_eq("rstmid_fresh_answer", 32'(answer), 32'd7);

    check_eq("final_sb_drain", 32'(sb.size()), 32'd0);
    check_eq("final_pulse_count", 32'(n_pulses), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
